// File: rtl/graph_pkg.sv
// -----------------------------------------------------------------------------
// graph_pkg
// Shared types and constants for the graph feature extractor pooling stage.
//   - PRECISION / TIME_WIDTH / COORD_WIDTH : default widths of features,
//     timestamps and event coordinates
//   - pool_mode_e   : feature merge mode (signed MAX, or saturating SUM)
//   - event_type    : x, y, t of one input-graph event
//   - pool_state_e  : RMW sequencer states, exported for debug visibility
//   - pooled_edge_idx : bit position of a pooled edge in the 18-bit mask
// -----------------------------------------------------------------------------
package graph_pkg;

    localparam int PRECISION     = 8;
    localparam int TIME_WIDTH    = 16;
    localparam int COORD_WIDTH   = 16;
    localparam int OUT_EDGE_BITS = 18;
    localparam int SELF_LOOP_IDX = 4;

    typedef enum logic {
        POOL_MAX,
        POOL_SUM
    } pool_mode_e;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
        logic [TIME_WIDTH-1:0]  t;
    } event_type;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_READ,
        ST_WAIT,
        ST_MERGE,
        ST_WRITE
    } pool_state_e;

    // Mask layout: two 3x3 planes (pdt = 0 / 1), row-major in (pdy, pdx).
    // Bit 4 is therefore the self loop (pdt=0, pdy=0, pdx=0).
    function automatic logic [4:0] pooled_edge_idx(input int pdt, input int pdy, input int pdx);
        return 5'(pdt * 9 + (pdy + 1) * 3 + (pdx + 1));
    endfunction

endpackage

// File: rtl/edge_pool_converter.sv
// -----------------------------------------------------------------------------
// edge_pool_converter
// Combinational mapper for a single neighbour edge of the current event onto
// the pooled output graph.
//   k        : neighbour index (selects the input-space offset dx, dy)
//   x, y, t  : coordinates and timestamp of the current event
//   edge_val : neighbour k is connected
//   edge_dt  : t(event) - t(neighbour k)
//   valid    : edge survives bounds and temporal checks
//   idx      : pooled edge mask bit for this edge (meaningful when valid)
// -----------------------------------------------------------------------------
module edge_pool_converter
    import graph_pkg::*;
#(
    parameter int IN_GRAPH_SIZE = 128,
    parameter int POOL_SIZE     = 4,
    parameter int T_POOL        = 4,
    parameter int RADIUS        = 1,
    parameter int KW            = 5
) (
    input  logic [KW-1:0]          k,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    input  logic [TIME_WIDTH-1:0]  t,
    input  logic                   edge_val,
    input  logic [TIME_WIDTH-1:0]  edge_dt,
    output logic                   valid,
    output logic [4:0]             idx
);

    localparam int W = 2 * RADIUS + 1;

    int   k_i, x_i, y_i, t_i, dt_i;
    int   dx, dy, nx, ny, pdx, pdy, pdt;
    logic in_bounds, t_ok;

    always_comb begin
        k_i  = int'(k);
        x_i  = int'(x);
        y_i  = int'(y);
        t_i  = int'(t);
        dt_i = int'(edge_dt);

        // Neighbour indices beyond W*W wrap onto the same offsets; the
        // resulting duplicate mask bits are simply ORed in.
        dx = (k_i % W) - RADIUS;
        dy = ((k_i / W) % W) - RADIUS;
        nx = x_i + dx;
        ny = y_i + dy;

        in_bounds = (nx >= 0) && (nx < IN_GRAPH_SIZE) && (ny >= 0) && (ny < IN_GRAPH_SIZE);

        // RADIUS < POOL_SIZE keeps these within {-1, 0, 1} once in bounds.
        pdx = (nx / POOL_SIZE) - (x_i / POOL_SIZE);
        pdy = (ny / POOL_SIZE) - (y_i / POOL_SIZE);

        // A neighbour stamped before time zero cannot exist.
        t_ok = (t_i >= dt_i);
        pdt  = (t_i / T_POOL) - ((t_i - dt_i) / T_POOL);

        valid = edge_val && in_bounds && t_ok && ((pdt == 0) || (pdt == 1));
        idx   = pooled_edge_idx(pdt, pdy, pdx);
    end

endmodule

// File: rtl/async_pool_rmw.sv
// -----------------------------------------------------------------------------
// async_pool_rmw
// Event-driven spatio-temporal pooling stage. One accepted event is converted
// into an 18-bit pooled edge mask, then the pooled vertex it lands on is
// read-modify-written in an external single-port RAM.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   in_valid/in_ready input handshake
//   in_event          x, y, t of the event
//   in_edge_val/dt    per-neighbour connection flag and time difference
//   in_features       signed features of the event
//   read              RAM read data, READ_LATENCY cycles after the read
//   write, addr       RAM write data ([17:0] edges, features above) / address
//   ena, wea          RAM enable / write enable
//   mem_ptr           active time-slot bank
//   bank_advance      one-cycle pulse when mem_ptr moves
//   done              one-cycle pulse coincident with the RAM write
//   dbg_state         current sequencer state
//
// Handshake: an event transfers on a rising clock edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE, so the block is
// single-issue; in_valid while busy has no effect and upstream must hold the
// event until it is accepted.
// -----------------------------------------------------------------------------
module async_pool_rmw
    import graph_pkg::*;
#(
    parameter int         IN_GRAPH_SIZE = 128,
    parameter int         POOL_SIZE     = 4,
    parameter int         T_POOL        = 4,
    parameter int         RADIUS        = 1,
    parameter int         PRECISION     = graph_pkg::PRECISION,
    parameter int         INPUT_DIM     = 16,
    parameter int         NUM_BANKS     = 3,
    parameter int         READ_LATENCY  = 1,
    parameter pool_mode_e MODE          = POOL_MAX,
    localparam int OUT_GRAPH_SIZE = IN_GRAPH_SIZE / POOL_SIZE,
    localparam int W              = 2 * RADIUS + 1,
    localparam int EDGE_NUM       = 2 * W * W,
    localparam int TW             = TIME_WIDTH,
    localparam int DATA_WIDTH     = INPUT_DIM * PRECISION + OUT_EDGE_BITS,
    localparam int ADDR_WIDTH     = $clog2(OUT_GRAPH_SIZE ** 2),
    localparam int PTR_WIDTH      = $clog2(NUM_BANKS)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  event_type                            in_event,
    input  logic [EDGE_NUM-1:0]                  in_edge_val,
    input  logic [EDGE_NUM-1:0][TW-1:0]          in_edge_dt,
    input  logic [INPUT_DIM-1:0][PRECISION-1:0] in_features,
    input  logic [DATA_WIDTH-1:0]                read,
    output logic [DATA_WIDTH-1:0]                write,
    output logic [ADDR_WIDTH-1:0]                addr,
    output logic                                 ena,
    output logic                                 wea,
    output logic [PTR_WIDTH-1:0]                 mem_ptr,
    output logic                                 bank_advance,
    output logic                                 done,
    output pool_state_e                          dbg_state
);

    localparam int CW = $clog2(EDGE_NUM);

    pool_state_e state_q, state_d;

    // Latched transaction
    event_type                            ev_q;
    logic [EDGE_NUM-1:0]                  val_q;
    logic [EDGE_NUM-1:0][TW-1:0]          dt_q;
    logic [INPUT_DIM-1:0][PRECISION-1:0]  feat_q;

    logic [CW-1:0]             conv_cnt;
    logic [1:0]                wait_cnt;
    logic [OUT_EDGE_BITS-1:0]  mask_q;

    // Bank ring
    logic [TW-1:0] last_slot;
    logic          first_flag;
    logic [TW-1:0] slot_in;

    logic                     edge_ok;
    logic [4:0]               edge_idx;
    logic [ADDR_WIDTH-1:0]    addr_calc;
    logic [DATA_WIDTH-1:0]    merged;
    logic                     accept;

    assign dbg_state = state_q;
    assign accept    = in_valid && in_ready;
    assign slot_in   = in_event.t / TW'(T_POOL);
    assign addr_calc = ADDR_WIDTH'((int'(ev_q.y) / POOL_SIZE) * OUT_GRAPH_SIZE
                                   + int'(ev_q.x) / POOL_SIZE);

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        ena      = 1'b0;
        wea      = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (conv_cnt == CW'(EDGE_NUM - 1)) state_d = ST_READ;
            end
            ST_READ: begin
                ena     = 1'b1;
                state_d = (READ_LATENCY > 1) ? ST_WAIT : ST_MERGE;
            end
            ST_WAIT: begin
                if (wait_cnt == 2'(READ_LATENCY - 2)) state_d = ST_MERGE;
            end
            ST_MERGE: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                ena     = 1'b1;
                wea     = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Edge conversion, one neighbour per CONVERT cycle
    // ---------------------------------------------------------------------
    edge_pool_converter #(
        .IN_GRAPH_SIZE(IN_GRAPH_SIZE),
        .POOL_SIZE    (POOL_SIZE),
        .T_POOL       (T_POOL),
        .RADIUS       (RADIUS),
        .KW           (CW)
    ) u_conv (
        .k       (conv_cnt),
        .x       (ev_q.x),
        .y       (ev_q.y),
        .t       (ev_q.t),
        .edge_val(val_q[conv_cnt]),
        .edge_dt (dt_q[conv_cnt]),
        .valid   (edge_ok),
        .idx     (edge_idx)
    );

    // ---------------------------------------------------------------------
    // Merge datapath: stored edges OR new edges OR self loop; features by mode
    // ---------------------------------------------------------------------
    logic signed [PRECISION-1:0] rd_f, in_f;
    logic signed [PRECISION:0]   sum_f;

    always_comb begin
        merged = '0;
        rd_f   = '0;
        in_f   = '0;
        sum_f  = '0;
        merged[OUT_EDGE_BITS-1:0] = read[OUT_EDGE_BITS-1:0] | mask_q
                                    | (OUT_EDGE_BITS'(1) << SELF_LOOP_IDX);
        for (int i = 0; i < INPUT_DIM; i++) begin
            rd_f  = $signed(read[OUT_EDGE_BITS + i * PRECISION +: PRECISION]);
            in_f  = $signed(feat_q[i]);
            sum_f = $signed({rd_f[PRECISION-1], rd_f}) + $signed({in_f[PRECISION-1], in_f});
            if (MODE == POOL_SUM) begin
                // Overflow when the carry-out disagrees with the sign bit.
                if (sum_f[PRECISION] != sum_f[PRECISION-1]) begin
                    merged[OUT_EDGE_BITS + i * PRECISION +: PRECISION] =
                        sum_f[PRECISION] ? {1'b1, {(PRECISION-1){1'b0}}}
                                         : {1'b0, {(PRECISION-1){1'b1}}};
                end else begin
                    merged[OUT_EDGE_BITS + i * PRECISION +: PRECISION] = sum_f[PRECISION-1:0];
                end
            end else begin
                merged[OUT_EDGE_BITS + i * PRECISION +: PRECISION] = (rd_f > in_f) ? rd_f : in_f;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_q         <= '0;
            val_q        <= '0;
            dt_q         <= '0;
            feat_q       <= '0;
            conv_cnt     <= '0;
            wait_cnt     <= '0;
            mask_q       <= '0;
            addr         <= '0;
            write        <= '0;
            mem_ptr      <= '0;
            last_slot    <= '0;
            first_flag   <= 1'b1;
            bank_advance <= 1'b0;
        end else begin
            bank_advance <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ev_q     <= in_event;
                        val_q    <= in_edge_val;
                        dt_q     <= in_edge_dt;
                        feat_q   <= in_features;
                        conv_cnt <= '0;
                        mask_q   <= '0;
                        // The first event after reset only seeds the slot
                        // history; later slot changes rotate the bank ring.
                        if (first_flag) begin
                            first_flag <= 1'b0;
                            last_slot  <= slot_in;
                        end else if (slot_in != last_slot) begin
                            last_slot    <= slot_in;
                            bank_advance <= 1'b1;
                            mem_ptr      <= (mem_ptr == PTR_WIDTH'(NUM_BANKS - 1))
                                            ? '0 : mem_ptr + 1'b1;
                        end
                    end
                end
                ST_CONVERT: begin
                    if (edge_ok) mask_q <= mask_q | (OUT_EDGE_BITS'(1) << edge_idx);
                    conv_cnt <= conv_cnt + 1'b1;
                    // addr only moves when the RAM access begins.
                    if (conv_cnt == CW'(EDGE_NUM - 1)) addr <= addr_calc;
                end
                ST_READ: begin
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                ST_MERGE: begin
                    write <= merged;
                end
                default: ;
            endcase
        end
    end

endmodule
